// File: rtl/demux_stream_1ton.sv
// Registered 1:NUM_OUT stream demultiplexer with valid/ready on every port.
// Each channel holds one beat; supports broadcast and counts dropped out-of-range beats.
module demux_stream_1ton #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int SEL_SPAN = 2 ** SEL_W;
    localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);

    generate
        if (SEL_SPAN < NUM_OUT || NUM_OUT < 2 || NUM_OUT > 16) begin : g_param_err
            $error("demux_stream_1ton: SEL_W too narrow for NUM_OUT or NUM_OUT outside 2..16");
        end
    endgenerate

    logic [NUM_OUT-1:0]  valid_reg;
    logic [NUM_OUT-1:0]  valid_next;
    logic [DATA_W-1:0]   data_reg  [NUM_OUT];
    logic [DATA_W-1:0]   data_next [NUM_OUT];
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;

    logic [NUM_OUT-1:0]  slot_free;
    logic [SEL_SPAN-1:0] slot_free_ext;
    logic [NUM_OUT-1:0]  load;
    logic                all_free;
    logic                sel_in_range;
    logic                accept;
    logic                drop;

    // Unused select codes read as "free" so out-of-range beats are always
    // accepted and routed to the drop path.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_free_ext
            if (gi < NUM_OUT) begin : g_real
                assign slot_free[gi]     = ~valid_reg[gi] | out_ready[gi];
                assign slot_free_ext[gi] = slot_free[gi];
            end else begin : g_drop
                assign slot_free_ext[gi] = 1'b1;
            end
        end
    endgenerate

    assign all_free     = &slot_free;
    assign sel_in_range = ({1'b0, in_sel} < NUM_OUT_W);
    assign in_ready     = rst_n & (in_bcast ? all_free : slot_free_ext[in_sel]);
    assign accept       = in_valid & in_ready;
    assign drop         = accept & ~in_bcast & ~sel_in_range;

    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_chan
            assign load[gi] = accept & (in_bcast | (in_sel == SEL_W'(gi)));

            always_comb begin
                valid_next[gi] = valid_reg[gi] & ~out_ready[gi];
                data_next[gi]  = data_reg[gi];
                if (load[gi]) begin
                    valid_next[gi] = 1'b1;
                    data_next[gi]  = in_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                end else begin
                    valid_reg[gi] <= valid_next[gi];
                    data_reg[gi]  <= data_next[gi];
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = data_reg[gi];
        end
    endgenerate

    // Saturating: once all ones, further drops leave the count pinned.
    always_comb begin
        cnt_next = cnt_reg;
        if (drop && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign out_valid = valid_reg;
    assign drop_cnt  = cnt_reg;

endmodule
